scrambler_256: RTL and testbench

SCRAMBLER_256 -- requirements
Module: scrambler_256

---
 rtl/pcs25g_pkg.sv | 28 ++
 rtl/skid_buffer_256.sv | 107 ++++++++++
 rtl/scrambler_256.sv | 74 +++++++
 tb/tb_scrambler_256.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs25g_pkg.sv
// Shared PCS constants, skid-buffer state encoding and the x^58+x^39+1 block scrambler.
package pcs25g_pkg;

  localparam int PCS_BLK_W = 256;
  localparam int SCR_LEN   = 58;
  localparam int SCR_TAP   = 39;
  localparam logic [SCR_LEN-1:0] SCR_SEED_DEFAULT = 58'h3FF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  // ext[SCR_LEN-1:0] holds the previous beat's last 58 scrambled bits; ext[SCR_LEN+i] is s[i].
  function automatic logic [PCS_BLK_W-1:0] scramble_blk(
    input logic [PCS_BLK_W-1:0] d,
    input logic [SCR_LEN-1:0]   h
  );
    logic [PCS_BLK_W+SCR_LEN-1:0] ext;
    ext = {{PCS_BLK_W{1'b0}}, h};
    for (int i = 0; i < PCS_BLK_W; i++) begin
      ext[SCR_LEN+i] = d[i] ^ ext[SCR_LEN-SCR_TAP+i] ^ ext[i];
    end
    return ext[PCS_BLK_W+SCR_LEN-1:SCR_LEN];
  endfunction

endpackage

// File: rtl/skid_buffer_256.sv
// Two-entry skid buffer (EMPTY/ONE/FULL) carrying a 256-bit block, its valid and its error flag.
module skid_buffer_256
  import pcs25g_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [PCS_BLK_W-1:0] push_data,
  input  logic                 push_error,
  output logic [PCS_BLK_W-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_error,
  output logic                 full
);

  skid_state_t          state_r;
  skid_state_t          state_s;
  logic                 load_out_s;
  logic                 out_from_skid_s;
  logic                 load_skid_s;
  logic [PCS_BLK_W-1:0] out_data_r;
  logic                 out_valid_r;
  logic                 out_error_r;
  logic [PCS_BLK_W-1:0] skid_data_r;
  logic                 skid_error_r;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= SKID_EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and register load selects; the head register always holds the oldest beat.
  always_comb begin
    state_s         = state_r;
    load_out_s      = 1'b0;
    out_from_skid_s = 1'b0;
    load_skid_s     = 1'b0;
    case (state_r)
      SKID_EMPTY: begin
        if (push) begin
          state_s    = SKID_ONE;
          load_out_s = 1'b1;
        end else begin
          state_s = SKID_EMPTY;
        end
      end
      SKID_ONE: begin
        if (push && pop) begin
          state_s    = SKID_ONE;
          load_out_s = 1'b1;
        end else if (push) begin
          state_s     = SKID_FULL;
          load_skid_s = 1'b1;
        end else if (pop) begin
          state_s = SKID_EMPTY;
        end else begin
          state_s = SKID_ONE;
        end
      end
      SKID_FULL: begin
        if (pop) begin
          state_s         = push ? SKID_FULL : SKID_ONE;
          load_out_s      = 1'b1;
          out_from_skid_s = 1'b1;
          load_skid_s     = push;
        end else begin
          state_s = SKID_FULL;
        end
      end
      default: begin
        state_s = SKID_EMPTY;
      end
    endcase
  end

  // Head and skid data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_r   <= {PCS_BLK_W{1'b0}};
      out_valid_r  <= 1'b0;
      out_error_r  <= 1'b0;
      skid_data_r  <= {PCS_BLK_W{1'b0}};
      skid_error_r <= 1'b0;
    end else begin
      out_valid_r <= (state_s != SKID_EMPTY);
      if (load_out_s) begin
        out_data_r  <= out_from_skid_s ? skid_data_r : push_data;
        out_error_r <= out_from_skid_s ? skid_error_r : push_error;
      end
      if (load_skid_s) begin
        skid_data_r  <= push_data;
        skid_error_r <= push_error;
      end
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_error = out_error_r;
  assign full      = (state_r == SKID_FULL);

endmodule

// File: rtl/scrambler_256.sv
// Self-synchronous 256-bit block scrambler (x^58+x^39+1) feeding a two-entry skid buffer.
// Optional macro SCR_BYPASS_EN adds in_bypass to pass beats unscrambled.
module scrambler_256
  import pcs25g_pkg::*;
#(
  parameter logic [SCR_LEN-1:0] SEED = SCR_SEED_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_enable,
  input  logic [PCS_BLK_W-1:0] in_data,
  input  logic                 in_datavalid,
  input  logic                 in_dataerror,
`ifdef SCR_BYPASS_EN
  input  logic                 in_bypass,
`endif
  output logic                 out_idle,
  output logic [PCS_BLK_W-1:0] out_data,
  output logic                 out_datavalid,
  output logic                 out_dataerror,
  input  logic                 in_idle
);

  logic [SCR_LEN-1:0]   hist_r;
  logic                 rst_done_r;
  logic                 full_s;
  logic                 accept_s;
  logic                 drain_s;
  logic                 hist_upd_s;
  logic [PCS_BLK_W-1:0] scr_s;
  logic [PCS_BLK_W-1:0] blk_s;

  assign accept_s = in_enable & in_datavalid & out_idle;
  assign drain_s  = in_enable & out_datavalid & in_idle;
  assign scr_s    = scramble_blk(in_data, hist_r);

`ifdef SCR_BYPASS_EN
  assign blk_s      = in_bypass ? in_data : scr_s;
  assign hist_upd_s = accept_s & ~in_bypass;
`else
  assign blk_s      = scr_s;
  assign hist_upd_s = accept_s;
`endif

  // Keeps out_idle low until the first clock after reset release.
  assign out_idle = in_enable & rst_done_r & ~full_s;

  // Scrambler history: last 58 scrambled bits of the most recent accepted beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_r     <= SEED;
      rst_done_r <= 1'b0;
    end else begin
      rst_done_r <= 1'b1;
      if (hist_upd_s) begin
        hist_r <= scr_s[PCS_BLK_W-1 -: SCR_LEN];
      end
    end
  end

  skid_buffer_256 u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (accept_s),
    .pop        (drain_s),
    .push_data  (blk_s),
    .push_error (in_dataerror),
    .out_data   (out_data),
    .out_valid  (out_datavalid),
    .out_error  (out_dataerror),
    .full       (full_s)
  );

endmodule

// File: tb/tb_scrambler_256.sv
// Self-checking bench for scrambler_256: vector table plus a scoreboard with a bit-serial reference model.
module tb_scrambler_256;

  localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [255:0] orig;
    logic [255:0] scr;
    logic         err;
  } exp_t;

  typedef struct {
    logic [255:0] d;
    logic         e;
    logic [255:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_enable;
  logic [255:0] in_data;
  logic         in_datavalid;
  logic         in_dataerror;
  logic         out_idle;
  logic [255:0] out_data;
  logic         out_datavalid;
  logic         out_dataerror;
  logic         in_idle;

  int   total = 0;
  int   passed = 0;
  int   acc_cnt, out_cnt, err_cnt, err_idx;
  bit   rand_idle = 1'b0;
  logic [57:0] enc_sr, dec_sr;
  exp_t sb[$];
  vec_t tbl[6];

  always #5 clk = ~clk;

  scrambler_256 dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_enable     (in_enable),
    .in_data       (in_data),
    .in_datavalid  (in_datavalid),
    .in_dataerror  (in_dataerror),
`ifdef SCR_BYPASS_EN
    .in_bypass     (1'b0),
`endif
    .out_idle      (out_idle),
    .out_data      (out_data),
    .out_datavalid (out_datavalid),
    .out_dataerror (out_dataerror),
    .in_idle       (in_idle)
  );

  // Serial history sr[k] = s[i-1-k]; the block seed holds s[-58..-1] in bits 0..57.
  function automatic logic [57:0] seed_sr(input logic [57:0] h);
    logic [57:0] r;
    for (int k = 0; k < 58; k++) r[k] = h[57-k];
    return r;
  endfunction

  function automatic logic [255:0] scr_model(input logic [255:0] d, input logic [57:0] sr_in,
                                             output logic [57:0] sr_out);
    logic [255:0] s;
    logic [57:0]  sr;
    logic         b;
    sr = sr_in;
    for (int i = 0; i < 256; i++) begin
      b    = d[i] ^ sr[38] ^ sr[57];
      s[i] = b;
      sr   = {sr[56:0], b};
    end
    sr_out = sr;
    return s;
  endfunction

  function automatic logic [255:0] desc_model(input logic [255:0] s, input logic [57:0] sr_in,
                                              output logic [57:0] sr_out);
    logic [255:0] d;
    logic [57:0]  sr;
    sr = sr_in;
    for (int i = 0; i < 256; i++) begin
      d[i] = s[i] ^ sr[38] ^ sr[57];
      sr   = {sr[56:0], s[i]};
    end
    sr_out = sr;
    return d;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Scoreboard: push the model result on acceptance, pop and compare on drain.
  task automatic monitor_loop();
    exp_t         e;
    logic [255:0] sd;
    logic [57:0]  nsr;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (in_enable && out_datavalid && in_idle) begin
          chk("sb_nonempty", 256'(sb.size() != 0), 256'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_data", out_data, e.scr);
            chk("out_err", 256'(out_dataerror), 256'(e.err));
            sd = desc_model(out_data, dec_sr, nsr);
            dec_sr = nsr;
            chk("descrambled", sd, e.orig);
          end
          if (out_dataerror) begin
            err_cnt++;
            err_idx = out_cnt;
          end
          out_cnt++;
        end
        if (in_enable && in_datavalid && out_idle) begin
          sd = scr_model(in_data, enc_sr, nsr);
          enc_sr = nsr;
          e.orig = in_data;
          e.scr  = sd;
          e.err  = in_dataerror;
          sb.push_back(e);
          acc_cnt++;
        end
      end
    end
  endtask

  task automatic clear_model();
    sb.delete();
    enc_sr  = seed_sr(SEED);
    dec_sr  = seed_sr(SEED);
    acc_cnt = 0;
    out_cnt = 0;
    err_cnt = 0;
    err_idx = -1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    in_datavalid = 1'b0;
    in_enable    = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    clear_model();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [255:0] d, input logic e);
    bit done = 1'b0;
    in_data      = d;
    in_dataerror = e;
    in_datavalid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      if (rand_idle) in_idle = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_enable && out_idle) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_datavalid = 1'b0;
    chk("accept_in_time", 256'(done), 256'd1);
  endtask

  task automatic drain();
    in_idle = 1'b1;
    for (int n = 0; n < 10 && sb.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 256'(sb.size()), 256'd0);
  endtask

  task automatic check_seed_pattern(input string tag);
    chk({tag, "_valid"}, 256'(out_datavalid), 256'd1);
    chk({tag, "_38_0"}, 256'(out_data[38:0]), 256'd0);
    chk({tag, "_57_39"}, 256'(out_data[57:39]), 256'h7FFFF);
    chk({tag, "_77_58"}, 256'(out_data[77:58]), 256'd0);
  endtask

  initial begin
    logic [255:0] a, b, c, cap;
    logic [57:0]  sr, sr2;
    logic         capv, cape;
    int           a0, o0;

    reset_n = 1'b0; in_enable = 1'b1; in_idle = 1'b1;
    in_data = '0; in_datavalid = 1'b0; in_dataerror = 1'b0;
    clear_model();
    fork monitor_loop(); join_none

    // Reset state and out_idle release timing.
    #3;
    chk("rst_valid", 256'(out_datavalid), 256'd0);
    chk("rst_data", out_data, 256'd0);
    chk("rst_err", 256'(out_dataerror), 256'd0);
    chk("rst_idle", 256'(out_idle), 256'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    #1;
    chk("idle_before_clk", 256'(out_idle), 256'd0);
    @(posedge clk); #1;
    chk("idle_after_clk", 256'(out_idle), 256'd1);

    // First zero beat from the seed, latency 1.
    send_beat(256'd0, 1'b0);
    check_seed_pattern("seed_beat");
    drain();

    // Table-driven vectors with model-computed expectations from the seed.
    tbl[0].d = 256'd0;                 tbl[0].e = 1'b0;
    tbl[1].d = {256{1'b1}};            tbl[1].e = 1'b0;
    tbl[2].d = {32{8'hA5}};            tbl[2].e = 1'b1;
    tbl[3].d = 256'd1;                 tbl[3].e = 1'b0;
    tbl[4].d = {1'b1, 255'd0};         tbl[4].e = 1'b1;
    tbl[5].d = rand256();              tbl[5].e = 1'b0;
    sr = seed_sr(SEED);
    for (int i = 0; i < 6; i++) begin
      tbl[i].exp = scr_model(tbl[i].d, sr, sr2);
      sr = sr2;
    end
    do_reset();
    in_idle = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_beat(tbl[i].d, tbl[i].e);
      chk("tbl_valid", 256'(out_datavalid), 256'd1);
      chk("tbl_data", out_data, tbl[i].exp);
      chk("tbl_err", 256'(out_dataerror), 256'(tbl[i].e));
    end
    drain();

    // Back-pressure: three back-to-back beats, only two fit.
    do_reset();
    in_idle = 1'b0;
    a = rand256(); b = rand256(); c = rand256();
    a0 = acc_cnt;
    in_data = a; in_dataerror = 1'b0; in_datavalid = 1'b1;
    @(posedge clk); #1;
    in_data = b;
    @(posedge clk); #1;
    chk("idle_when_full", 256'(out_idle), 256'd0);
    in_data = c;
    cap = out_data;
    repeat (5) @(posedge clk);
    #1;
    chk("two_accepted", 256'(acc_cnt - a0), 256'd2);
    chk("idle_still_low", 256'(out_idle), 256'd0);
    chk("stall_data_hold", out_data, cap);
    chk("stall_valid_hold", 256'(out_datavalid), 256'd1);
    in_idle = 1'b1;
    send_beat(c, 1'b0);
    drain();
    chk("three_out", 256'(out_cnt), 256'd3);

    // Error flag on beat 5 only.
    do_reset();
    in_idle = 1'b1;
    for (int i = 0; i < 10; i++) send_beat(rand256(), i == 5);
    drain();
    chk("err_count", 256'(err_cnt), 256'd1);
    chk("err_index", 256'(err_idx), 256'd5);

    // Reset while FULL, then restart from the seed.
    do_reset();
    in_idle = 1'b0;
    send_beat(rand256(), 1'b0);
    send_beat(rand256(), 1'b1);
    chk("full_idle", 256'(out_idle), 256'd0);
    chk("full_valid", 256'(out_datavalid), 256'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 256'(out_datavalid), 256'd0);
    chk("midrst_data", out_data, 256'd0);
    chk("midrst_err", 256'(out_dataerror), 256'd0);
    chk("midrst_idle", 256'(out_idle), 256'd0);
    do_reset();
    in_idle = 1'b1;
    send_beat(256'd0, 1'b0);
    check_seed_pattern("post_rst");
    drain();

    // Long random stream with random stalls and an enable gap mid-stream.
    do_reset();
    rand_idle = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if (n == 500) begin
        in_enable = 1'b0;
        in_idle = 1'b1;
        in_data = rand256();
        in_datavalid = 1'b1;
        a0 = acc_cnt; o0 = out_cnt;
        cap = out_data; capv = out_datavalid; cape = out_dataerror;
        repeat (10) @(posedge clk);
        #1;
        chk("gap_data", out_data, cap);
        chk("gap_valid", 256'(out_datavalid), 256'(capv));
        chk("gap_err", 256'(out_dataerror), 256'(cape));
        chk("gap_no_accept", 256'(acc_cnt), 256'(a0));
        chk("gap_no_drain", 256'(out_cnt), 256'(o0));
        chk("gap_idle", 256'(out_idle), 256'd0);
        in_datavalid = 1'b0;
        in_enable = 1'b1;
      end
      send_beat(rand256(), $urandom_range(0, 15) == 0);
    end
    rand_idle = 1'b0;
    drain();
    chk("stream_accepted", 256'(acc_cnt), 256'd1000);
    chk("stream_out", 256'(out_cnt), 256'd1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
